// File: rtl/hpdl_bus_capture.sv
// hpdl_bus_capture: HPDL-1414 write-bus monitor with shadow frame buffer and event FIFO
module hpdl_bus_capture #(
    parameter int unsigned MIN_WR_LOW = 3,
    parameter logic [6:0]  CHAR_RESET = 7'h20,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] HPDL_D,
    input  logic [1:0] HPDL_A,
    input  logic [3:0] HPDL_WR_N,
    input  logic [3:0] rd_addr,
    output logic [6:0] rd_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_addr,
    output logic [6:0] evt_char,
    input  logic       clr_flags,
    output logic       err_multi,
    output logic       err_glitch,
    output logic       err_ovf
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  MIN_CNT = 4'(MIN_WR_LOW);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOW, ABORT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wr1_q, wr2_q;
    logic [6:0]  d1_q, d2_q;
    logic [1:0]  a1_q, a2_q;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  fb_q [16];
    logic [6:0]  rd_data_q;
    logic [10:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic        err_multi_q, err_glitch_q, err_ovf_q;

    logic [3:0]  low_v;
    logic [1:0]  low_idx;
    logic [3:0]  wr_idx;
    logic        all_high, one_low, commit, set_multi, set_glitch;
    logic        empty, full, pop, push, set_ovf;

    always_comb begin
        low_v      = ~wr2_q;
        all_high   = low_v == 4'd0;
        one_low    = !all_high && (low_v & (low_v - 4'd1)) == 4'd0;
        // Index encode of a one-hot vector; only consulted when one_low holds.
        low_idx    = {low_v[3] | low_v[2], low_v[3] | low_v[1]};
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        set_multi  = 1'b0;
        set_glitch = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_low) begin
                    state_d = LOW;
                    sel_d   = low_idx;
                    cnt_d   = 4'd1;
                end else if (!all_high) begin
                    state_d   = ABORT;
                    set_multi = 1'b1;
                end
            end
            LOW: begin
                if (all_high) begin
                    state_d    = IDLE;
                    commit     = cnt_q >= MIN_CNT;
                    set_glitch = cnt_q < MIN_CNT;
                end else if (one_low && low_idx == sel_q) begin
                    cnt_d = cnt_q + {3'd0, cnt_q != 4'hF};
                end else begin
                    state_d   = ABORT;
                    set_multi = 1'b1;
                end
            end
            default: state_d = all_high ? IDLE : ABORT;
        endcase
    end

    assign wr_idx    = {sel_q, a2_q};
    assign empty     = wp_q == rp_q;
    assign full      = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    assign pop       = !empty && evt_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push      = commit && (!full || pop);
    assign set_ovf   = commit && full && !pop;
    assign evt_valid = !empty;
    assign {evt_addr, evt_char} = mem_q[rp_q[AW-1:0]];
    assign rd_data    = rd_data_q;
    assign err_multi  = err_multi_q;
    assign err_glitch = err_glitch_q;
    assign err_ovf    = err_ovf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr1_q        <= 4'hF;
            wr2_q        <= 4'hF;
            d1_q         <= 7'd0;
            d2_q         <= 7'd0;
            a1_q         <= 2'd0;
            a2_q         <= 2'd0;
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            cnt_q        <= 4'd0;
            rd_data_q    <= CHAR_RESET;
            wp_q         <= '0;
            rp_q         <= '0;
            err_multi_q  <= 1'b0;
            err_glitch_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            for (int i = 0; i < 16; i++) fb_q[i] <= CHAR_RESET;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 11'd0;
        end else begin
            wr1_q        <= HPDL_WR_N;
            wr2_q        <= wr1_q;
            d1_q         <= HPDL_D;
            d2_q         <= d1_q;
            a1_q         <= HPDL_A;
            a2_q         <= a1_q;
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= fb_q[rd_addr];
            err_multi_q  <= (err_multi_q & ~clr_flags) | set_multi;
            err_glitch_q <= (err_glitch_q & ~clr_flags) | set_glitch;
            err_ovf_q    <= (err_ovf_q & ~clr_flags) | set_ovf;
            if (commit) fb_q[wr_idx] <= d2_q;
            if (push) begin
                mem_q[wp_q[AW-1:0]] <= {wr_idx, d2_q};
                wp_q                <= wp_q + PTR_ONE;
            end
            if (pop) rp_q <= rp_q + PTR_ONE;
        end
    end
endmodule

// File: doc/hpdl_bus_capture.md
Name: hpdl_bus_capture

Overview:
- Display-side responder for the four-device HPDL-1414 write bus: D[6:0], A[1:0] and four active-low WR strobes.
- Decodes each valid write into a 16-entry shadow frame buffer (digit index = {WR select, A}). Emits each write as an event through a valid/ready stream.
- Used as an on-board monitor and as a bench responder for display drivers, checking what the display would show.

Parameters:
- MIN_WR_LOW, 3: minimum synchronized WR-low cycles for a valid write; shorter pulses are glitches.
- CHAR_RESET, 7'h20: value loaded into every buffer entry at reset.
- FIFO_DEPTH, 4: event FIFO depth; power of two, 2..16.

Ports:
- CLK  in  1  system clock, 12 MHz
- RST_N  in  1  asynchronous active-low reset
- HPDL_D  in  7  bus data, asynchronous to CLK
- HPDL_A  in  2  bus digit address within a device
- HPDL_WR_N  in  4  active-low write strobes; bit k selects device k
- rd_addr  in  4  shadow buffer read index
- rd_data  out  7  shadow buffer read data, registered
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_addr  out  4  event digit index {sel, A}
- evt_char  out  7  event character
- clr_flags  in  1  one-cycle pulse; clears sticky flags
- err_multi  out  1  sticky: more than one WR low, or the select changed during a pulse
- err_glitch  out  1  sticky: WR pulse shorter than MIN_WR_LOW
- err_ovf  out  1  sticky: event dropped because the FIFO was full

Behaviour:
- Reset values (async assert, sync-released use): all buffer entries = CHAR_RESET, rd_data = CHAR_RESET, evt_valid = 0, evt_addr = 0, evt_char = 0, all flags = 0, FSM = IDLE, FIFO empty.
- Synchronization:
  - Every bus input passes through a 2-flop synchronizer.
  - WR_N synchronizer flops reset to 1; D and A synchronizer flops reset to 0.
  - All decoding uses synchronized values only, so D and A stay aligned with WR.
- Low counter: 4-bit, saturating at 15.
- FSM IDLE:
  - Exactly one synchronized WR_N bit low: latch sel = its index, set low counter to 1, go to LOW.
  - More than one bit low: set err_multi, go to ABORT.
- FSM LOW:
  - Each cycle the same single bit stays low: low counter increments (saturating).
  - Another bit goes low, or the select changes: set err_multi, go to ABORT.
  - All WR_N high with count >= MIN_WR_LOW: commit, go to IDLE.
  - All WR_N high with count < MIN_WR_LOW: set err_glitch, no commit, go to IDLE.
- FSM ABORT: wait until all WR_N are high, then go to IDLE; no commit.
- Commit (the cycle the rising edge is detected):
  - Index = {sel, synchronized A}; data = synchronized D from the same cycle, which is the value held while WR was low.
  - Buffer write and FIFO push both take effect at the next clock edge.
- Read port:
  - rd_data <= buf[rd_addr] every cycle: 1-cycle latency.
  - Read and commit to the same index in the same cycle returns the old value; the new value appears on the following read.
- Event stream:
  - evt_valid = FIFO non-empty; evt_addr and evt_char show the head entry.
  - A pop occurs on evt_valid & evt_ready.
  - Head fields hold stable while evt_valid is high and evt_ready is low.
- FIFO full:
  - A commit with no pop in the same cycle drops the event and sets err_ovf; the buffer is still updated.
  - Push and pop in the same cycle while full is accepted; occupancy stays unchanged.
- Flags:
  - Sticky until clr_flags.
  - A flag set and clr_flags in the same cycle: set wins.
- Reset mid-pulse: FSM returns to IDLE. A bus already low when RST_N releases is treated as a new pulse once the synchronizer sees it low; its counter starts fresh.
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH, with one extra bit for full/empty disambiguation.

Test Plan:
- Reset, then read all 16 indices -> rd_data = 7'h20 on each, one cycle after rd_addr; evt_valid = 0, flags = 0.
- Write 'A' (7'h41) with WR_N[2] low for 5 cycles, A = 2'b01 -> one event with evt_addr = 4'h9, evt_char = 7'h41; rd_addr = 9 then returns 7'h41.
- Drive 16 writes in the driver's sweep order (sel = addr[3:2], A = addr[1:0]) with chars 0x30..0x3F -> buf[i] = 0x30 + i for every i; events arrive in order with ready held high.
- WR_N[0] low for 2 cycles -> no event, buffer unchanged, err_glitch = 1; a clr_flags pulse returns it to 0.
- WR_N[1] and WR_N[3] low together for 6 cycles -> err_multi = 1, no commit; the next clean write still commits.
- Hold evt_ready = 0 through 5 valid writes -> first 4 events retained in order, 5th dropped, err_ovf = 1, buf holds all 5 chars; then assert ready -> 4 pops, then evt_valid = 0.
